led_flasher: RTL and testbench

I2C-controlled two-LED blinker: a 7-bit-addressed I2C slave writes a small 6-bit register file, and the register file sets the red/green LED blink pattern and rate. It is the top-level logic of the board's flasher image. It drives the LEDR/LEDG pins directly and shares the board I2C bus through open-drain SDA/SCL.

---
 rtl/led_flasher.sv | 271 +++++++++++++++++++++++++++
 tb/tb_led_flasher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_flasher.sv
// I2C-slave-controlled red/green LED blinker with a small 6-bit register file.
// Build option FLASHER_LSB_FIRST_EN: shift every byte LSB-first (R/W bit first on the wire).
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | bus idle or not addressed, SDA released
// ST_ADDR      | shifting in address byte
// ST_ACK_ADDR  | driving ACK for matched address
// ST_WRITE     | shifting in a {tag, val} write byte
// ST_ACK_WR    | driving ACK for write byte, commit on its 9th fall
// ST_READ      | shifting out {2'b00, reg[pointer]} plus master ACK slot
// ST_ACK_RD_WAIT | master NACKed, SDA released until STOP/START

module led_flasher #(
   parameter logic [6:0]  I2C_ADDR      = 7'h41,
   parameter int unsigned PRESCALE_BITS = 18,
   parameter logic [5:0]  RATE_RESET    = 6'd15
) (
   input  logic CLK,
   input  logic GSRn,
   inout  wire  SDA,
   inout  wire  SCL,
   output logic LEDR,
   output logic LEDG
);

   localparam logic [5:0] ID_VAL     = 6'h2A;
   localparam logic [1:0] TAG_A_ADDR = 2'b00;
   localparam logic [1:0] TAG_D_ADDR = 2'b01;
   localparam logic [5:0] REG_RATE   = 6'd1;
   localparam logic [5:0] REG_MODE   = 6'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK_ADDR,
      ST_WRITE,
      ST_ACK_WR,
      ST_READ,
      ST_ACK_RD_WAIT
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic       sda_oe, sda_oe_nxt;
   logic       mack, mack_nxt;
   logic       wr_stb;

   logic sda_s1, sda_s2, sda_d;
   logic scl_s1, scl_s2, scl_d;
   logic scl_rise, scl_fall, start_det, stop_det;

   logic [5:0] pointer;
   logic [5:0] rate;
   logic [5:0] mode;
   logic [5:0] rd_data;
   logic [7:0] rd_byte;

   logic [PRESCALE_BITS-1:0] presc;
   logic                     tick;
   logic [5:0]               blink_cnt;
   logic                     phase;

   // open-drain: only ever pull SDA low; SCL is never driven
   assign SDA = sda_oe ? 1'b0 : 1'bz;
   assign SCL = 1'bz;

   always_ff @(posedge CLK or negedge GSRn) begin
      if (!GSRn) begin
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
         sda_d  <= 1'b1;
         scl_s1 <= 1'b1;
         scl_s2 <= 1'b1;
         scl_d  <= 1'b1;
      end else begin
         sda_s1 <= SDA;
         sda_s2 <= sda_s1;
         sda_d  <= sda_s2;
         scl_s1 <= SCL;
         scl_s2 <= scl_s1;
         scl_d  <= scl_s2;
      end
   end

   assign scl_rise  =  scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 &  scl_d;
   assign start_det =  scl_s2 &  scl_d & sda_d & ~sda_s2;
   assign stop_det  =  scl_s2 &  scl_d & ~sda_d & sda_s2;

   function automatic logic tx_bit(input logic [7:0] b, input logic [2:0] n);
`ifdef FLASHER_LSB_FIRST_EN
      return b[n];
`else
      return b[3'd7 - n];
`endif
   endfunction

   function automatic logic [7:0] shift_in(input logic [7:0] b, input logic d);
`ifdef FLASHER_LSB_FIRST_EN
      return {d, b[7:1]};
`else
      return {b[6:0], d};
`endif
   endfunction

   always_ff @(posedge CLK or negedge GSRn) begin
      if (!GSRn) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         sda_oe  <= 1'b0;
         mack    <= 1'b1;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shreg   <= shreg_nxt;
         sda_oe  <= sda_oe_nxt;
         mack    <= mack_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      sda_oe_nxt  = sda_oe;
      mack_nxt    = mack;
      wr_stb      = 1'b0;
      if (start_det) begin
         state_nxt   = ST_ADDR;
         bit_cnt_nxt = '0;
         sda_oe_nxt  = 1'b0;
      end else if (stop_det) begin
         state_nxt   = ST_IDLE;
         bit_cnt_nxt = '0;
         sda_oe_nxt  = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               sda_oe_nxt = 1'b0;
            end
            ST_ADDR: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  shreg_nxt   = shift_in(shreg, sda_s2);
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  if (shreg[7:1] == I2C_ADDR) begin
                     state_nxt  = ST_ACK_ADDR;
                     sda_oe_nxt = 1'b1;
                  end else begin
                     state_nxt  = ST_IDLE;
                  end
               end
            end
            ST_ACK_ADDR: begin
               if (scl_fall) begin
                  bit_cnt_nxt = '0;
                  if (shreg[0]) begin
                     state_nxt  = ST_READ;
                     shreg_nxt  = rd_byte;
                     sda_oe_nxt = ~tx_bit(rd_byte, 3'd0);
                  end else begin
                     state_nxt  = ST_WRITE;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            ST_WRITE: begin
               if (scl_rise && bit_cnt < 4'd8) begin
                  shreg_nxt   = shift_in(shreg, sda_s2);
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  state_nxt  = ST_ACK_WR;
                  sda_oe_nxt = 1'b1;
               end
            end
            ST_ACK_WR: begin
               if (scl_fall) begin
                  wr_stb      = 1'b1;
                  state_nxt   = ST_WRITE;
                  bit_cnt_nxt = '0;
                  sda_oe_nxt  = 1'b0;
               end
            end
            ST_READ: begin
               // bit_cnt counts SCL rises seen: 8 data bits, then the master ACK slot
               if (scl_rise && bit_cnt <= 4'd8) begin
                  if (bit_cnt == 4'd8) mack_nxt = sda_s2;
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt < 4'd8) begin
                     sda_oe_nxt = ~tx_bit(shreg, bit_cnt[2:0]);
                  end else if (bit_cnt == 4'd8) begin
                     sda_oe_nxt = 1'b0;
                  end else if (!mack) begin
                     shreg_nxt   = rd_byte;
                     bit_cnt_nxt = '0;
                     sda_oe_nxt  = ~tx_bit(rd_byte, 3'd0);
                  end else begin
                     state_nxt  = ST_ACK_RD_WAIT;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            ST_ACK_RD_WAIT: begin
               sda_oe_nxt = 1'b0;
            end
            default: begin
               state_nxt  = ST_IDLE;
               sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge GSRn) begin
      if (!GSRn) begin
         pointer <= '0;
         rate    <= RATE_RESET;
         mode    <= '0;
      end else if (wr_stb) begin
         if (shreg[7:6] == TAG_A_ADDR) begin
            pointer <= shreg[5:0];
         end else if (shreg[7:6] == TAG_D_ADDR) begin
            case (pointer)
               REG_RATE: rate <= shreg[5:0];
               REG_MODE: mode <= shreg[5:0];
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (pointer)
         6'd0:     rd_data = ID_VAL;
         REG_RATE: rd_data = rate;
         REG_MODE: rd_data = mode;
         default:  rd_data = '0;
      endcase
   end

   assign rd_byte = {2'b00, rd_data};

   always_ff @(posedge CLK or negedge GSRn) begin
      if (!GSRn) begin
         presc     <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         presc <= presc - PRESCALE_BITS'(1);
         if (tick) begin
            // counter above a freshly lowered RATE wraps through 63 before matching
            if (blink_cnt == rate) begin
               blink_cnt <= '0;
               if (!mode[1]) phase <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 6'd1;
            end
         end
      end
   end

   assign tick = (presc == '0);
   assign LEDR = phase;
   assign LEDG = mode[0] ? phase : ~phase;

endmodule

// File: tb/tb_led_flasher.sv
// Directed bench for led_flasher: I2C register access, address filtering and blink timing.
`timescale 1ns/1ps

module tb_led_flasher;

   localparam int Q = 10;
   localparam int EDGE_TIMEOUT = 3000;

   logic clk = 1'b0;
   logic gsr_n;
   logic sda_lo;
   logic scl_lo;
   wire  sda;
   wire  scl;
   wire  ledr;
   wire  ledg;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int slave_low = 0;

   assign sda = sda_lo ? 1'b0 : 1'bz;
   assign scl = scl_lo ? 1'b0 : 1'bz;
   pullup (sda);
   pullup (scl);

   always #25 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (!sda_lo && sda === 1'b0) slave_low <= slave_low + 1;

   led_flasher #(
      .I2C_ADDR(7'h41),
      .PRESCALE_BITS(4),
      .RATE_RESET(6'd15)
   ) dut (
      .CLK(clk),
      .GSRn(gsr_n),
      .SDA(sda),
      .SCL(scl),
      .LEDR(ledr),
      .LEDG(ledg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int wire_idx(input int i);
`ifdef FLASHER_LSB_FIRST_EN
      return i;
`else
      return 7 - i;
`endif
   endfunction

   task automatic i2c_start;
      sda_lo = 1'b0; wait_clk(Q);
      scl_lo = 1'b0; wait_clk(Q);
      sda_lo = 1'b1; wait_clk(Q);
      scl_lo = 1'b1; wait_clk(Q);
   endtask

   task automatic i2c_stop;
      sda_lo = 1'b1; wait_clk(Q);
      scl_lo = 1'b0; wait_clk(Q);
      sda_lo = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_bit(input logic b, output logic r);
      sda_lo = ~b;   wait_clk(Q);
      scl_lo = 1'b0; wait_clk(Q);
      r = sda;       wait_clk(Q);
      scl_lo = 1'b1; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 0; i < 8; i++) i2c_bit(d[wire_idx(i)], r);
      i2c_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic r;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         i2c_bit(1'b1, r);
         d[wire_idx(i)] = r;
      end
      i2c_bit(nack, r);
   endtask

   task automatic write_reg(input logic [5:0] ptr, input logic [5:0] val);
      logic ack;
      i2c_start;
      write_byte(8'h82, ack);           check("wr_addr_ack", ack, 1);
      write_byte({2'b00, ptr}, ack);    check("wr_ptr_ack", ack, 1);
      write_byte({2'b01, val}, ack);    check("wr_data_ack", ack, 1);
      i2c_stop;
   endtask

   task automatic read_reg(input logic [5:0] ptr, output logic [7:0] d);
      logic ack;
      i2c_start;
      write_byte(8'h82, ack);           check("rd_waddr_ack", ack, 1);
      write_byte({2'b00, ptr}, ack);    check("rd_ptr_ack", ack, 1);
      i2c_start;
      write_byte(8'h83, ack);           check("rd_raddr_ack", ack, 1);
      read_byte(1'b1, d);
      i2c_stop;
   endtask

   task automatic wait_led_edge(output int at, output logic ok);
      logic prev;
      prev = ledr;
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < EDGE_TIMEOUT; i++) begin
         @(negedge clk);
         if (ledr !== prev) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic measure_period(input string tag, input int exp);
      int t0, t1, t2;
      logic ok0, ok1, ok2;
      wait_led_edge(t0, ok0);
      wait_led_edge(t1, ok1);
      wait_led_edge(t2, ok2);
      check({tag, "_edges_seen"}, {ok0 & ok1 & ok2}, 1);
      check({tag, "_period1"}, t1 - t0, exp);
      check({tag, "_period2"}, t2 - t1, exp);
   endtask

   initial begin
      logic [7:0] d;
      logic ack, r, ok;
      int base, t;

      sda_lo = 1'b0;
      scl_lo = 1'b0;
      gsr_n  = 1'b0;
      #300;
      check("rst_ledr", ledr, 0);
      check("rst_ledg", ledg, 1);
      check("rst_sda", sda, 1);
      check("rst_scl", scl, 1);
      @(negedge clk);
      gsr_n = 1'b1;
      wait_clk(4);

      read_reg(6'd2, d);
      check("rst_mode_read", d, 8'h00);
      read_reg(6'd1, d);
      check("rst_rate_read", d, 8'h0F);
      check("alt_leds", ledg, !ledr);
      measure_period("rate15", 256);

      // MODE=1: sync blinking
      write_reg(6'd2, 6'd1);
      read_reg(6'd2, d);
      check("mode_read", d, 8'h01);
      for (int k = 0; k < 3; k++) begin
         wait_led_edge(t, ok);
         check("sync_edge_seen", ok, 1);
         check("sync_leds", ledg, ledr);
      end

      // foreign address: no ACK, SDA untouched, following byte ignored
      base = slave_low;
      i2c_start;
      write_byte(8'h40, ack);
      check("foreign_addr_nack", ack, 0);
      write_byte(8'h40, ack);
      check("foreign_data_nack", ack, 0);
      i2c_stop;
      check("foreign_sda_untouched", slave_low - base, 0);
      read_reg(6'd2, d);
      check("foreign_mode_kept", d, 8'h01);

      // RATE=3 then RATE=0 with 16-CLK ticks
      write_reg(6'd1, 6'd3);
      read_reg(6'd1, d);
      check("rate3_read", d, 8'h03);
      measure_period("rate3", 64);
      write_reg(6'd1, 6'd0);
      measure_period("rate0", 16);

      // ID read twice (ACK then NACK), then SDA stays released
      i2c_start;
      write_byte(8'h82, ack);  check("id_waddr_ack", ack, 1);
      write_byte(8'h00, ack);  check("id_ptr_ack", ack, 1);
      i2c_start;
      write_byte(8'h83, ack);  check("id_raddr_ack", ack, 1);
      read_byte(1'b0, d);      check("id_read1", d, 8'h2A);
      read_byte(1'b1, d);      check("id_read2", d, 8'h2A);
      base = slave_low;
      i2c_bit(1'b1, r);        check("after_nack_bit1", r, 1);
      i2c_bit(1'b1, r);        check("after_nack_bit2", r, 1);
      check("after_nack_released", slave_low - base, 0);
      i2c_stop;

      // reset during 5th data bit of a RATE=5 write
      write_reg(6'd2, 6'd0);
      i2c_start;
      write_byte(8'h82, ack);  check("abort_addr_ack", ack, 1);
      write_byte(8'h01, ack);  check("abort_ptr_ack", ack, 1);
      d = 8'h45;
      for (int i = 0; i < 4; i++) i2c_bit(d[wire_idx(i)], r);
      sda_lo = ~d[wire_idx(4)];
      wait_clk(Q);
      scl_lo = 1'b0;
      wait_clk(Q / 2);
      gsr_n = 1'b0;
      wait_clk(2);
      sda_lo = 1'b0;
      wait_clk(Q);
      check("abort_sda_released", sda, 1);
      check("abort_ledr", ledr, 0);
      check("abort_ledg", ledg, 1);
      gsr_n = 1'b1;
      wait_clk(Q);

      // pointer back to 0 after reset: a bare read returns ID
      i2c_start;
      write_byte(8'h83, ack);  check("post_rst_raddr_ack", ack, 1);
      read_byte(1'b1, d);      check("post_rst_ptr0_id", d, 8'h2A);
      i2c_stop;
      read_reg(6'd1, d);
      check("post_rst_rate", d, 8'h0F);
      write_reg(6'd2, 6'd1);
      read_reg(6'd2, d);
      check("post_rst_mode_write", d, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
